// File: rtl/aes_pkg.sv
// Shared constants and helpers for the AES inverse-cipher flow control.
// Derives the round count from the key length and sizes the occupancy counter.
// Holds no logic; it is imported by the controller and its pipeline slots.
package aes_pkg;

  // Default key length in 32-bit words (AES-128)
  localparam int NK_DEFAULT = 4;

  // Number of rounds for a given key length
  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  // Width of a counter that must hold 0..nr+1 (every stage occupied)
  function automatic int cnt_w_of(input int nr);
    return $clog2(nr + 2);
  endfunction

  // Occupancy counter width for the default configuration
  localparam int CNT_W_DEFAULT = cnt_w_of(nr_of(NK_DEFAULT));

endpackage

// File: rtl/aes_pipe_slot.sv
// One datapath stage of flow state: occupancy bit plus the tag riding with the block.
// Zero-cycle enable decision; occupancy and tag update on the following edge.
// Loads when the upstream stage holds a block and this stage is empty or draining.
module aes_pipe_slot
  import aes_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             src,       // upstream stage holds a block (or input offered)
  input  logic             down_adv,  // downstream can take this stage's block now
  input  logic             flush,
  input  logic [TAG_W-1:0] tag_in,
  output logic             en,        // load enable for this datapath stage
  output logic             occ,
  output logic [TAG_W-1:0] tag
);

  // Load when something is upstream and there is (or will be) room here
  always_comb begin
    en = src && (!occ || down_adv);
  end

  // Occupancy: set on load, cleared when the block leaves without a refill, wiped by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= 1'b0;
    end else if (flush) begin
      occ <= 1'b0;
    end else if (en) begin
      occ <= 1'b1;
    end else if (occ && down_adv) begin
      occ <= 1'b0;
    end
  end

  // Tag follows the same enable as the datapath register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= '0;
    end else if (en) begin
      tag <= tag_in;
    end
  end

endmodule

// File: rtl/aes_inv_ctrl.sv
// Elastic, bubble-collapsing flow controller for the Nr+1 stage AES inverse cipher datapath.
// Latency Nr+1 cycles from accept to out_valid with no stalls; one block per cycle sustained.
// Full backpressure: out_ready low holds stage 0 and lets upstream bubbles close; in_ready drops only when all stages are full.
module aes_inv_ctrl
  import aes_pkg::*;
#(
  parameter int Nk    = NK_DEFAULT,
  parameter int Nr    = nr_of(Nk),
  parameter int TAG_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic                      key_ready,
  input  logic                      flush,
  output logic [0:Nr]               stage_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      idle,
  output logic [$clog2(Nr+2)-1:0]   inflight
);

  localparam int CW = cnt_w_of(Nr);

  logic [0:Nr]      occ;
  logic [0:Nr]      src;
  logic [0:Nr]      room;
  logic             in_room;
  logic [TAG_W-1:0] tag     [0:Nr];
  logic [TAG_W-1:0] tag_src [0:Nr];
  logic             accept;
  logic             drain;

  // Downstream advance per stage. The ripple "stage k-1 moves" only matters when stage k is
  // full, so it reduces to: out_ready, or a hole anywhere below. Computing it as a prefix-OR
  // over occupancy keeps the out_ready-to-in_ready path combinational without a self-feeding vector.
  always_comb begin
    logic hole;
    hole    = 1'b0;
    room    = '0;
    for (int k = 0; k <= Nr; k++) begin
      room[k] = out_ready || hole;
      hole    = hole || !occ[k];
    end
    in_room = out_ready || hole;
  end

  // Sources: the top stage is fed from the request port, every other stage from the one above
  always_comb begin
    src     = '0;
    tag_src = '{default: '0};
    for (int k = 0; k < Nr; k++) begin
      src[k]     = occ[k+1];
      tag_src[k] = tag[k+1];
    end
    src[Nr]     = in_valid && key_ready && !flush;
    tag_src[Nr] = in_tag;
  end

  for (genvar k = 0; k <= Nr; k++) begin : g_slot
    aes_pipe_slot #(
      .TAG_W (TAG_W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .src      (src[k]),
      .down_adv (room[k]),
      .flush    (flush),
      .tag_in   (tag_src[k]),
      .en       (stage_en[k]),
      .occ      (occ[k]),
      .tag      (tag[k])
    );
  end

  // Port-level status derived from occupancy
  always_comb begin
    in_ready  = key_ready && !flush && in_room;
    out_valid = occ[0];
    out_tag   = tag[0];
    idle      = ~|occ;
    accept    = stage_en[Nr];
    drain     = occ[0] && out_ready;
  end

  // Registered occupancy count, kept alongside occ rather than recounted every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else if (accept && !drain) begin
      inflight <= inflight + CW'(1);
    end else if (drain && !accept) begin
      inflight <= inflight - CW'(1);
    end
  end

  // The top-stage enable is the input handshake
  a_accept_is_handshake : assert property (@(posedge clk) disable iff (!rst_n)
    accept == (in_valid && in_ready));

  // The counter must always agree with the occupancy vector
  a_inflight_matches_occ : assert property (@(posedge clk) disable iff (!rst_n)
    int'(inflight) == $countones(occ));

endmodule

// File: tb/tb_aes_inv_ctrl.sv
module tb_aes_inv_ctrl;
  import aes_pkg::*;

  localparam int NR = 10;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_tag;
  logic                     key_ready;
  logic                     flush;
  logic [0:NR]              stage_en;
  logic                     out_valid;
  logic                     out_ready;
  logic [3:0]               out_tag;
  logic                     idle;
  logic [CNT_W_DEFAULT-1:0] inflight;

  int n_chk;
  int n_pass;

  aes_inv_ctrl #(.Nk(4), .Nr(NR), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .key_ready (key_ready),
    .flush     (flush),
    .stage_en  (stage_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .idle      (idle),
    .inflight  (inflight)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // One cycle: drive inputs just after the falling edge, settle, then sample
  task automatic cyc(input logic v, input logic [3:0] t, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_tag    = t;
    out_ready = ordy;
    #1;
  endtask

  // Accept one block with out_ready high and measure accept-to-out_valid latency
  task automatic run_single(input logic [3:0] t, input string name);
    int lat;
    cyc(1'b1, t, 1'b1);
    check({name, "_in_ready"}, int'(in_ready), 1);
    check({name, "_en_top"}, int'(stage_en[NR]), 1);
    lat = 0;
    do begin
      cyc(1'b0, 4'd0, 1'b1);
      lat++;
    end while (!out_valid && lat < 40);
    check({name, "_latency"}, lat, NR + 1);
    check({name, "_tag"}, int'(out_tag), int'(t));
    cyc(1'b0, 4'd0, 1'b1);
    check({name, "_idle_after"}, int'(idle), 1);
  endtask

  initial begin
    int acc;
    int n_out;
    int first;
    int last;
    int drops;

    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_tag    = 4'd0;
    key_ready = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_idle", int'(idle), 1);
    check("rst_stage_en", $countones(stage_en), 0);
    check("rst_inflight", int'(inflight), 0);
    check("rst_in_ready_key1", int'(in_ready), 1);
    key_ready = 1'b0;
    #1;
    check("rst_in_ready_key0", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // key_ready low blocks accepts
    cyc(1'b1, 4'd3, 1'b1);
    check("nokey_in_ready", int'(in_ready), 0);
    check("nokey_en_top", int'(stage_en[NR]), 0);
    cyc(1'b0, 4'd0, 1'b1);
    check("nokey_idle", int'(idle), 1);
    key_ready = 1'b1;

    // Single block latency and tag
    run_single(4'hA, "single");

    // Back-to-back stream of 20 blocks, continuous out_ready
    n_out = 0; first = -1; last = -1; drops = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(i < 20, 4'(i), 1'b1);
      if (i < 20 && !in_ready) drops++;
      if (out_valid) begin
        check("b2b_tag", int'(out_tag), n_out % 16);
        if (first < 0) first = i;
        last = i;
        n_out++;
      end
    end
    check("b2b_in_ready_drops", drops, 0);
    check("b2b_count", n_out, 20);
    check("b2b_first", first, NR + 1);
    check("b2b_last", last, NR + 20);
    check("b2b_idle", int'(idle), 1);

    // Fill against a stalled consumer
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 4'(acc), 1'b0);
      if (in_ready) acc++;
    end
    check("stall_accepts", acc, NR + 1);
    check("stall_in_ready", int'(in_ready), 0);
    check("stall_inflight", int'(inflight), NR + 1);
    check("stall_out_valid", int'(out_valid), 1);
    check("stall_out_tag", int'(out_tag), 0);
    // Release: output and accept in the same cycles
    for (int j = 0; j < NR + 1; j++) begin
      cyc(1'b1, 4'(acc), 1'b1);
      check("release_out_valid", int'(out_valid), 1);
      check("release_out_tag", int'(out_tag), j);
      check("release_in_ready", int'(in_ready), 1);
      if (in_ready) acc++;
    end
    for (int j = 0; j < NR + 1; j++) begin
      cyc(1'b0, 4'd0, 1'b1);
      if (j == 0) check("release_full_inflight", int'(inflight), NR + 1);
      check("drain_out_valid", int'(out_valid), 1);
      check("drain_out_tag", int'(out_tag), (NR + 1 + j) % 16);
    end
    cyc(1'b0, 4'd0, 1'b1);
    check("drain_idle", int'(idle), 1);

    // Bubble collapse: blocks at cycles 0 and 4, consumer stalled until cycle 30
    for (int b = 0; b < 33; b++) begin
      cyc(b == 0 || b == 4, (b == 0) ? 4'd1 : 4'd2, b >= 30);
      if (b == 13) begin
        check("bub_c13_en1", int'(stage_en[1]), 1);
        check("bub_c13_en_cnt", $countones(stage_en), 1);
      end
      if (b == 14) begin
        check("bub_c14_en_cnt", $countones(stage_en), 0);
        check("bub_c14_inflight", int'(inflight), 2);
        check("bub_c14_out_tag", int'(out_tag), 1);
      end
      if (b == 29) check("bub_c29_out_valid", int'(out_valid), 1);
      if (b == 30) check("bub_c30_out_tag", int'(out_tag), 1);
      if (b == 31) begin
        check("bub_c31_out_valid", int'(out_valid), 1);
        check("bub_c31_out_tag", int'(out_tag), 2);
      end
      if (b == 32) check("bub_c32_out_valid", int'(out_valid), 0);
    end

    // Flush with five blocks in flight
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'(i), 1'b0);
    check("flush_pre_inflight", int'(inflight), 4);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    #1;
    check("flush_in_ready", int'(in_ready), 0);
    check("flush_en_top", int'(stage_en[NR]), 0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_idle", int'(idle), 1);
    check("flush_inflight", int'(inflight), 0);
    check("flush_out_valid", int'(out_valid), 0);
    check("flush_in_ready_after", int'(in_ready), 1);

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 15; i++) cyc(1'b1, 4'(i), 1'b1);
    check("arst_pre_out_valid", int'(out_valid), 1);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_stage_en", $countones(stage_en), 0);
    check("arst_inflight", int'(inflight), 0);
    check("arst_idle", int'(idle), 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_single(4'h7, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
